// File: rtl/argmax_row_sched.sv
// ---------------------------------------------------------------------------
// argmax_row_sched
//
// Shared, time-multiplexed argmax engine. It walks N rows of CHAR_NUM signed
// logits, each delivered as BEATS beats of LANES logits. For every row it
// finds the index of the largest logit and writes it into the packed result
// q. A tie always goes to the lowest index.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous reset, active-high
//   run      in   start pulse, only looked at while idle
//   d_valid  in   input beat valid
//   d_ready  out  engine accepts a beat (high only while loading)
//   d        in   beat, lane k = d[k*N_LEN +: N_LEN] = logit beat*LANES+k
//   busy     out  high from run accept until the result pulse
//   valid    out  one-cycle pulse, q complete
//   q        out  per-row argmax, row i in q[i*CHAR_LEN +: CHAR_LEN]
// ---------------------------------------------------------------------------
module argmax_row_sched #(
  parameter int N        = 10,
  parameter int CHAR_NUM = 200,
  parameter int N_LEN    = 16,
  parameter int CHAR_LEN = 8,
  parameter int LANES    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     d_valid,
  output logic                     d_ready,
  input  logic [LANES*N_LEN-1:0]   d,
  output logic                     busy,
  output logic                     valid,
  output logic [N*CHAR_LEN-1:0]    q
);

  localparam int BEATS = (CHAR_NUM + LANES - 1) / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = (N > 1) ? $clog2(N) : 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BW-1:0]              beat_cnt;
  logic [RW-1:0]              row_cnt;
  logic signed [N_LEN-1:0]    run_max;
  logic [CHAR_LEN-1:0]        run_idx;

  logic signed [N_LEN-1:0]    lane_val;
  logic signed [N_LEN-1:0]    beat_max;
  logic [LW-1:0]              beat_lane;
  logic [CHAR_LEN-1:0]        beat_idx;
  logic signed [N_LEN-1:0]    win_max;
  logic [CHAR_LEN-1:0]        win_idx;

  logic accept;
  logic last_beat;
  logic last_row;
  logic start;

  assign accept    = d_ready & d_valid;
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign last_row  = (row_cnt == RW'(N - 1));
  assign start     = (state == S_IDLE) & run;

  // ---- beat compare: combinational winner of the current beat ----
  // Lane 0 always holds a real logit, so it seeds the search. Scanning
  // upward with strict '>' keeps the lowest lane on ties. Lanes past
  // CHAR_NUM on a short last beat never win.
  always_comb begin
    lane_val  = '0;
    beat_max  = $signed(d[N_LEN-1:0]);
    beat_lane = '0;
    for (int k = 1; k < LANES; k++) begin
      lane_val = $signed(d[k*N_LEN +: N_LEN]);
      if (((int'(beat_cnt) * LANES + k) < CHAR_NUM) && (lane_val > beat_max)) begin
        beat_max  = lane_val;
        beat_lane = LW'(k);
      end
    end
    beat_idx = CHAR_LEN'(int'(beat_cnt) * LANES + int'(beat_lane));
  end

  // Merge with the running max. The first beat of a row loads
  // unconditionally; later beats must be strictly greater, so an equal
  // value in a later beat keeps the earlier (lower) index.
  always_comb begin
    if ((beat_cnt == '0) || (beat_max > run_max)) begin
      win_max = beat_max;
      win_idx = beat_idx;
    end else begin
      win_max = run_max;
      win_idx = run_idx;
    end
  end

  // ---- control: state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_LOAD;
      S_LOAD:  if (accept && last_beat && last_row) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    d_ready = (state == S_LOAD);
    busy    = (state == S_LOAD);
    valid   = (state == S_DONE);
  end

  // ---- counters and result slots ----
  // q is only cleared by reset; a new run overwrites it row by row so
  // untouched slots keep the previous result until their row commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      row_cnt  <= '0;
      q        <= '0;
    end else if (start) begin
      beat_cnt <= '0;
      row_cnt  <= '0;
    end else if (accept) begin
      if (last_beat) begin
        beat_cnt <= '0;
        row_cnt  <= last_row ? '0 : row_cnt + RW'(1);
        for (int i = 0; i < N; i++) begin
          if (row_cnt == RW'(i)) q[i*CHAR_LEN +: CHAR_LEN] <= win_idx;
        end
      end else begin
        beat_cnt <= beat_cnt + BW'(1);
      end
    end
  end

  // Running max is pure data: cleared at run start and reloaded by the
  // first beat of every row, so stale contents after reset never leak.
  always_ff @(posedge clk) begin
    if (start) begin
      run_max <= '0;
      run_idx <= '0;
    end else if (accept) begin
      run_max <= win_max;
      run_idx <= win_idx;
    end
  end

endmodule

// File: tb/tb_argmax_row_sched.sv
// ---------------------------------------------------------------------------
// Bench for argmax_row_sched. Rows of logits are held in a plain array; the
// expected result of a run is the first index of the maximum of each row,
// queued when the run starts. A monitor pops and compares on every valid.
// ---------------------------------------------------------------------------
module tb_argmax_row_sched;

  localparam int N        = 10;
  localparam int CHAR_NUM = 200;
  localparam int N_LEN    = 16;
  localparam int CHAR_LEN = 8;
  localparam int LANES    = 8;
  localparam int BEATS    = (CHAR_NUM + LANES - 1) / LANES;

  typedef struct {
    logic [N*CHAR_LEN-1:0] q;
    bit                    cont;
    int                    run_edge;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   run;
  logic                   d_valid;
  logic                   d_ready;
  logic [LANES*N_LEN-1:0] d;
  logic                   busy;
  logic                   valid;
  logic [N*CHAR_LEN-1:0]  q;

  argmax_row_sched #(
    .N(N), .CHAR_NUM(CHAR_NUM), .N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .d_valid(d_valid), .d_ready(d_ready),
    .d(d), .busy(busy), .valid(valid), .q(q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_hs_edge = 0;
  int rows [N][CHAR_NUM];
  logic [N*CHAR_LEN-1:0] model_q = '0;
  exp_t sb [$];
  exp_t mon_e;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: first index holding the row maximum.
  function automatic int ref_idx(input int r);
    int best = 0;
    for (int i = 1; i < CHAR_NUM; i++)
      if (rows[r][i] > rows[r][best]) best = i;
    return best;
  endfunction

  function automatic logic [N*CHAR_LEN-1:0] ref_q();
    logic [N*CHAR_LEN-1:0] e = '0;
    for (int r = 0; r < N; r++) e[r*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(ref_idx(r));
    return e;
  endfunction

  task automatic set_rows_peak();
    for (int r = 0; r < N; r++)
      for (int i = 0; i < CHAR_NUM; i++)
        rows[r][i] = (i == (17*r + 3) % CHAR_NUM) ? 32767 : -32768;
  endtask

  task automatic set_rows_edge();
    for (int i = 0; i < CHAR_NUM; i++) begin
      rows[0][i] = 5;
      rows[1][i] = -300;
      rows[2][i] = int'($urandom_range(0, 32867)) - 32768;
      rows[3][i] = -2;
      rows[4][i] = -32768;
    end
    rows[1][50]  = -1;
    rows[1][120] = -1;
    rows[2][34]  = 100;
    rows[2][38]  = 100;
    rows[3][199] = 1;
    for (int r = 5; r < N; r++)
      for (int i = 0; i < CHAR_NUM; i++)
        rows[r][i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic rand_rows(input bit narrow);
    for (int r = 0; r < N; r++)
      for (int i = 0; i < CHAR_NUM; i++)
        rows[r][i] = narrow ? int'($urandom_range(0, 6)) - 3
                            : int'($urandom_range(0, 65535)) - 32768;
  endtask

  // Called right after a posedge (+#1). Queues the expected result.
  task automatic start_run(input bit cont);
    exp_t e;
    e.q    = ref_q();
    e.cont = cont;
    run = 1'b1;
    @(negedge clk);
    e.run_edge = cyc + 1;
    chk("run_accepted_from_idle", busy, 0);
    sb.push_back(e);
    model_q = e.q;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic send_beat(input int r, input int b, input bit gaps);
    logic [LANES*N_LEN-1:0] pk;
    logic [N_LEN-1:0] v;
    bit hs;
    int n;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        d_valid = 1'b0;
        d = {4{$urandom}};
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < LANES; k++) begin
      int idx = b*LANES + k;
      v = (idx < CHAR_NUM) ? N_LEN'(rows[r][idx]) : N_LEN'($urandom);
      pk[k*N_LEN +: N_LEN] = v;
    end
    d = pk;
    d_valid = 1'b1;
    hs = 1'b0;
    n = 0;
    while (!hs) begin
      @(negedge clk);
      hs = d_ready;
      if (hs) last_hs_edge = cyc + 1;
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        $display("FAIL handshake_timeout row=%0d beat=%0d actual=no_ready required=ready", r, b);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "handshake timeout");
      end
    end
  endtask

  task automatic feed(input int r0, input int r1, input bit gaps);
    for (int r = r0; r < r1; r++)
      for (int b = 0; b < BEATS; b++)
        send_beat(r, b, gaps);
    d_valid = 1'b0;
  endtask

  task automatic check_q_zero(input string name);
    for (int i = 0; i < N; i++) chk(name, q[i*CHAR_LEN +: CHAR_LEN], 0);
  endtask

  // Monitor: compare on every valid, and watch handshake signalling.
  always @(negedge clk) begin
    chk("ready_only_in_load", d_ready, busy);
    if (valid) begin
      chk("valid_not_busy", busy, 0);
      chk("valid_after_last_hs", cyc, last_hs_edge);
      chk("pending_results", sb.size(), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        for (int i = 0; i < N; i++)
          chk($sformatf("q_slot%0d", i), q[i*CHAR_LEN +: CHAR_LEN], mon_e.q[i*CHAR_LEN +: CHAR_LEN]);
        if (mon_e.cont) chk("run_to_valid_cycles", cyc - mon_e.run_edge + 1, N*BEATS + 1);
      end
    end
  end

  initial begin
    logic [N*CHAR_LEN-1:0] old_q;
    rst = 1'b1; run = 1'b0; d_valid = 1'b0; d = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", d_ready, 0);
    chk("rst_valid", valid, 0);
    check_q_zero("rst_q");
    @(posedge clk); #1;
    rst = 1'b0;

    // Beats offered while idle are ignored
    d_valid = 1'b1; d = {4{$urandom}};
    repeat (3) @(posedge clk); #1;
    d_valid = 1'b0;

    // Single peak per row, continuous stream; run again in DONE is ignored
    set_rows_peak();
    start_run(1);
    feed(0, N, 0);
    run = 1'b1;
    @(negedge clk);
    chk("peak_slot0", q[0 +: CHAR_LEN], 3);
    chk("peak_slot9", q[9*CHAR_LEN +: CHAR_LEN], 156);
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    chk("run_in_done_ignored", busy, 0);
    @(posedge clk); #1;

    // Ties, signed compare, last lane
    set_rows_edge();
    start_run(1);
    feed(0, N, 0);
    @(negedge clk);
    chk("tie_all_equal", q[0 +: CHAR_LEN], 0);
    chk("tie_across_beats", q[1*CHAR_LEN +: CHAR_LEN], 50);
    chk("tie_in_beat", q[2*CHAR_LEN +: CHAR_LEN], 34);
    chk("last_lane_pos", q[3*CHAR_LEN +: CHAR_LEN], 199);
    chk("all_min", q[4*CHAR_LEN +: CHAR_LEN], 0);
    @(posedge clk); #1;

    // Gaps on the peak data with stray run pulses at cycles 10 and 250
    set_rows_peak();
    start_run(0);
    fork
      begin
        repeat (9) @(posedge clk);
        #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        repeat (239) @(posedge clk);
        #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
      end
    join_none
    feed(0, N, 1);
    wait fork;
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // Partial overwrite: finished rows new, the rest keep the old result
    old_q = model_q;
    rand_rows(1);
    start_run(0);
    feed(0, 3, 0);
    repeat (4) @(posedge clk); #1;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      chk($sformatf("partial_slot%0d", i), q[i*CHAR_LEN +: CHAR_LEN],
          (i < 3) ? model_q[i*CHAR_LEN +: CHAR_LEN] : old_q[i*CHAR_LEN +: CHAR_LEN]);
    @(posedge clk); #1;
    feed(3, N, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset mid-run at row 4 beat 12, run held with rst
    rand_rows(0);
    start_run(0);
    feed(0, 4, 0);
    for (int b = 0; b < 12; b++) send_beat(4, b, 0);
    rst = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0; d_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", d_ready, 0);
    chk("midrst_valid", valid, 0);
    check_q_zero("midrst_q");
    @(negedge clk);
    chk("run_with_rst_ignored", busy, 0);
    sb.delete();
    model_q = '0;
    @(posedge clk); #1;

    // Fresh runs after the reset, mixed data and flow control
    for (int t = 0; t < 4; t++) begin
      rand_rows(t[0]);
      start_run(t < 2);
      feed(0, N, t >= 2);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end

    repeat (5) @(posedge clk);
    chk("all_results_seen", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/argmax_row_sched.md
Name: argmax_row_sched

Overview:
- Time-multiplexed replacement for the N parallel 200-way comparators at the network output.
- One shared argmax engine walks N rows of CHAR_NUM signed logits. Each row arrives as a stream of LANES-wide beats, and the engine produces the per-row winning character index.
- Sits between the final dense layer's output buffer (stream source) and the character decoder. Output format matches the existing packed q layout: row i in q[i*CHAR_LEN +: CHAR_LEN].

Parameters:
- N, 10, rows per run.
- CHAR_NUM, 200, logits per row.
- N_LEN, 16, logit width, two's-complement signed.
- CHAR_LEN, 8, index width; must satisfy 2^CHAR_LEN >= CHAR_NUM.
- LANES, 8, logits per input beat; BEATS = ceil(CHAR_NUM/LANES), 25 at defaults.

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous reset, active-high.
- run, in, 1, start pulse; sampled only in IDLE.
- d_valid, in, 1, input beat valid.
- d_ready, out, 1, engine accepts beat.
- d, in, LANES*N_LEN, beat; lane k = d[k*N_LEN +: N_LEN] = logit (beat*LANES + k).
- busy, out, 1, high from run accept until valid pulse.
- valid, out, 1, one-cycle pulse; q complete.
- q, out, N*CHAR_LEN, packed per-row argmax indices.

Behaviour:
- Reset values: d_ready=0, busy=0, valid=0, q=0. Internal state is IDLE with all counters at 0.
- States and transitions:
  - IDLE to LOAD on run=1. Clears the row counter, beat counter and running max. q is NOT cleared at start, only overwritten row by row.
  - LOAD: d_ready=1. A beat is accepted on a cycle with d_valid&d_ready.
  - LOAD to DONE on acceptance of beat BEATS-1 of row N-1.
  - DONE lasts exactly 1 cycle: valid=1, busy=0, then IDLE.
- busy: 1 in LOAD, 0 in IDLE and DONE. run while busy or in DONE is ignored.
- Beat compare (combinational):
  - Lanes with global index >= CHAR_NUM are masked. On the last beat this is lanes CHAR_NUM-(BEATS-1)*LANES .. LANES-1; at defaults none are masked.
  - Signed comparison; strict greater-than.
  - Tie resolves to the lowest index, both within a beat and across beats.
- Running max register:
  - On the first beat of a row, load the beat winner unconditionally.
  - On later beats, replace only if beat max > running max.
  - The index is stored as CHAR_LEN bits: beat*LANES + lane.
- Row commit: on acceptance of beat BEATS-1, write the final winner index (running max merged with this beat) into q slot row_cnt in the same edge. Then increment row_cnt and reset beat_cnt to 0.
- Latency:
  - Slot i of q updates on the edge that accepts row i's last beat.
  - valid is asserted the cycle after the final beat is accepted.
  - Minimum run to valid is N*BEATS+1 cycles with d_valid held high: 251 at defaults.
- q holds its value after valid until it is overwritten by the next run.
- Back-pressure: the source may deassert d_valid at any time. Counters and running max hold while d_valid=0, with no timeout.
- Input beats offered in IDLE/DONE are not accepted (d_ready=0) and have no effect.
- rst mid-run: the next cycle is IDLE with q=0, valid=0 and no partial result retained. run asserted together with rst is ignored.
- Width rule: beat_cnt is sized ceil(log2(BEATS)) bits and row_cnt ceil(log2(N)) bits; neither wraps within a run.

Test Plan:
- Each row r has its single maximum logit 0x7FFF at index (17*r+3) mod 200 and all others 0x8000. Continuous d_valid -> valid at cycle 251 after run; q slot r = (17*r+3) mod 200, e.g. slot 0=3, slot 9=156.
- Row of all-equal logits 0x0005, plus a row with the value -1 at indices 50 and 120 and -300 elsewhere -> indices 0 and 50 (lowest-index tie-break across beats). A duplicate max inside one beat (lanes 2 and 6 of beat 4) -> index 34.
- Signed check: row with -2 everywhere except +1 at index 199 (last lane of last beat) -> 199. A row whose max is -32768 at all positions -> 0.
- Random d_valid gaps (50% duty, seeded) on the same data as the first scenario -> identical q. valid occurs exactly once, one cycle after the last handshake. d_ready is never high outside LOAD.
- run pulsed again at cycles 10 and 250 of a run -> ignored, single valid. A new run after DONE overwrites q row by row; unfinished slots keep their old values until written.
- rst asserted at row 4 beat 12 -> next cycle busy=0, d_ready=0, q=0. A subsequent full run produces correct q with no carry-over of running max.
